tm_pingpong_writer: RTL
=======================

// Module: tm_pingpong_writer
// PURPOSE
//  Upstream producer for the TM frame reader. Accepts a CPU-side byte stream and writes complete
//  frames into the ping-pong dual-port RAM: bank A at base 0, bank B at base 512.
//  Raises Flag_A_Tx/Flag_B_Tx when a bank holds a full frame; releases the bank on the reader's Finish.
// PARAMETERS
//  FRAME_LEN    223  bytes per frame written to RAM (offsets 0..FRAME_LEN-1)
//  BANK_B_BASE  512  RAM base address of bank B; bank A base is 0
//  DROP_W       16   width of Drop_Count
// PORTS
//  ClkI_Dec2         in   1   single clock, all logic on posedge
//  Rst               in   1   asynchronous reset, active-high
//  Frame_Start       in   1   qualifies Wr_En byte as first byte of a frame
//  Wr_En             in   1   byte strobe, one byte per cycle max
//  Wr_Data           in   8   byte
//  Flag_A_Tx_Finish  in   1   reader done with bank A (level, high >=1 cycle)
//  Flag_B_Tx_Finish  in   1   reader done with bank B
//  Wr_Ready          out  1   a free bank exists or a fill is in progress
//  USER_WEN_TRP1     out  1   RAM write enable
//  USER_WA_TRP1      out  10  RAM write address
//  USER_WD_TRP1      out  8   RAM write data
//  Flag_A_Tx         out  1   bank A full, owned by reader
//  Flag_B_Tx         out  1   bank B full, owned by reader
//  pending           out  1   Flag_A_Tx | Flag_B_Tx
//  Drop_Count        out  DROP_W  bytes discarded, saturating
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, offset=0, next-bank pointer=A, Finish edge detectors cleared.
//  Reset mid-fill: partial frame discarded, both flags cleared; reader must be reset with it.
//  FSM IDLE: Wr_En&Frame_Start&free bank -> FILL, byte written at offset 0.
//    Bank choice: the free one; if both free, next-bank pointer (alternates A,B,A...).
//    Wr_En without Frame_Start, or no free bank -> byte dropped, Drop_Count+1.
//  FSM FILL: each Wr_En writes at base+offset, offset+1.
//    Frame_Start inside FILL: partial frame abandoned, Drop_Count += offset (saturating),
//    new frame restarts at offset 0 of same bank.
//    Byte at offset FRAME_LEN-1 -> COMMIT.
//  FSM COMMIT (1 cycle): set Flag_x_Tx of filled bank, toggle next-bank pointer, -> IDLE.
//    Wr_Ready low in COMMIT; Wr_En there is dropped and counted.
//  Write latency: Wr_En at cycle n -> USER_WEN_TRP1/WA/WD valid cycle n+1, single cycle.
//    Flag_x_Tx rises cycle n+2 after the last byte's strobe, never before its RAM write.
//  Wr_Ready = (FSM==FILL) | (FSM==IDLE & (!Flag_A_Tx | !Flag_B_Tx)), registered.
//  Release: rising edge of Flag_x_Tx_Finish (registered detect) clears Flag_x_Tx next cycle.
//    Finish stays high several cycles; only the edge acts. Finish for an unflagged bank: ignored.
//  Simultaneous: COMMIT of one bank and Finish edge of the other in the same cycle -> both act.
//    Finish edge of bank X in the cycle X would be chosen: X not free until flag cleared.
//  Address arithmetic: WA = base + offset, 10 bits, offset < FRAME_LEN, no wrap into other bank.
//  Drop_Count saturates at all-ones, no wrap.
// CONFIGURATION
//  TM_FRAME_SEQ_EN defined: writer inserts an 8-bit frame sequence number at offset 0;
//    CPU supplies FRAME_LEN-1 bytes, written at offsets 1..FRAME_LEN-1. First data byte
//    (Frame_Start) takes offset 1; the seq byte is written in COMMIT cycle. Seq increments per
//    committed frame, wraps 255->0, resets to 0. Flag rises the cycle after the seq write.
//  Undefined: no insertion; CPU supplies all FRAME_LEN bytes; COMMIT performs no RAM write.
// TESTING
//  1 Reset, stream 223 bytes 0x00..0xDE with Frame_Start on first -> writes 0..222 bank A,
//    Flag_A_Tx=1 two cycles after last strobe, pending=1.
//  2 Second frame -> bank B addr 512..734, Flag_B_Tx=1; third frame: Wr_Ready=0, 223 bytes
//    dropped, Drop_Count=223.
//  3 Hold Flag_A_Tx_Finish high 8 cycles -> Flag_A_Tx clears once; next frame goes to A;
//    Finish for B while Flag_B_Tx=0 -> no effect.
//  4 Frame_Start after 100 bytes -> Drop_Count+=100, new frame restarts at base, completes at 223.
//  5 Commit to B and Flag_A_Tx_Finish edge same cycle -> Flag_B_Tx=1 and Flag_A_Tx=0 next cycle.
//  6 With TM_FRAME_SEQ_EN: three frames of 222 bytes -> offset 0 holds 0x00,0x01,0x02; Rst
//    asserted mid-frame clears flags, seq back to 0.

Source files
------------

// File: rtl/tm_pingpong_writer.sv
// tm_pingpong_writer
// Upstream producer for the TM frame reader. Takes a CPU byte stream and writes whole
// frames into a ping-pong dual-port RAM (bank A at 0, bank B at BANK_B_BASE). A bank is
// handed to the reader by raising its Flag_x_Tx; the reader hands it back with a rising
// edge on Flag_x_Tx_Finish.
// Optional feature macro: TM_FRAME_SEQ_EN -- the writer inserts an 8-bit frame sequence
// number at offset 0 of every frame. The CPU then supplies only FRAME_LEN-1 bytes.
module tm_pingpong_writer #(
  parameter int FRAME_LEN   = 223,
  parameter int BANK_B_BASE = 512,
  parameter int DROP_W      = 16
) (
  input  logic              ClkI_Dec2,
  input  logic              Rst,
  input  logic              Frame_Start,
  input  logic              Wr_En,
  input  logic [7:0]        Wr_Data,
  input  logic              Flag_A_Tx_Finish,
  input  logic              Flag_B_Tx_Finish,
  output logic              Wr_Ready,
  output logic              USER_WEN_TRP1,
  output logic [9:0]        USER_WA_TRP1,
  output logic [7:0]        USER_WD_TRP1,
  output logic              Flag_A_Tx,
  output logic              Flag_B_Tx,
  output logic              pending,
  output logic [DROP_W-1:0] Drop_Count
);

`ifdef TM_FRAME_SEQ_EN
  localparam bit SeqEn = 1'b1;
`else
  localparam bit SeqEn = 1'b0;
`endif

  localparam int ADDR_W = 10;
  localparam int OFF_W  = $clog2(FRAME_LEN);

  // CPU data starts at offset 1 when offset 0 is reserved for the sequence byte.
  localparam logic [OFF_W-1:0]  FirstOff = OFF_W'(SeqEn ? 1 : 0);
  localparam logic [OFF_W-1:0]  OffOne   = OFF_W'(1);
  localparam logic [OFF_W-1:0]  LastOff  = OFF_W'(FRAME_LEN - 1);
  localparam logic [ADDR_W-1:0] BaseB    = ADDR_W'(BANK_B_BASE);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [OFF_W-1:0]    offset_q, offset_d;
  logic                bankSel_q, bankSel_d;
  logic                nextBank_q, nextBank_d;
  logic                flagA_q, flagA_d;
  logic                flagB_q, flagB_d;
  logic                setA_q, setA_d;
  logic                setB_q, setB_d;
  logic                finDlyA_q, finDlyB_q;
  logic [7:0]          seq_q, seq_d;
  logic                wen_q, wen_d;
  logic [ADDR_W-1:0]   wa_q, wa_d;
  logic [7:0]          wd_q, wd_d;
  logic                ready_q, ready_d;
  logic [DROP_W-1:0]   drop_q, drop_d;

  logic                finEdgeA, finEdgeB;
  logic                freeA, freeB;
  logic                pickB;
  logic [OFF_W-1:0]    dropInc;
  logic [DROP_W:0]     dropSum;

  // RAM address of a byte: bank base plus in-frame offset. Offsets stay below FRAME_LEN,
  // so a frame never spills into the other bank.
  function automatic logic [ADDR_W-1:0] addrOf(input logic bankB, input logic [OFF_W-1:0] off);
    logic [ADDR_W-1:0] base;
    base = bankB ? BaseB : '0;
    return base + {{(ADDR_W-OFF_W){1'b0}}, off};
  endfunction

  // A bank is busy while the reader owns it or while its flag is about to be raised.
  assign finEdgeA = Flag_A_Tx_Finish & ~finDlyA_q;
  assign finEdgeB = Flag_B_Tx_Finish & ~finDlyB_q;
  assign freeA    = ~(flagA_q | setA_q);
  assign freeB    = ~(flagB_q | setB_q);

  // Next-state logic: frame fill FSM, RAM write port, bank flags and drop accounting.
  always_comb begin
    state_d    = state_q;
    offset_d   = offset_q;
    bankSel_d  = bankSel_q;
    nextBank_d = nextBank_q;
    flagA_d    = flagA_q;
    flagB_d    = flagB_q;
    setA_d     = 1'b0;
    setB_d     = 1'b0;
    seq_d      = seq_q;
    wen_d      = 1'b0;
    wa_d       = wa_q;
    wd_d       = wd_q;
    dropInc    = '0;
    pickB      = 1'b0;

    case (state_q)
      IDLE: begin
        if (Wr_En) begin
          if (Frame_Start && (freeA || freeB)) begin
            pickB     = (freeA && freeB) ? nextBank_q : freeB;
            bankSel_d = pickB;
            wen_d     = 1'b1;
            wa_d      = addrOf(pickB, FirstOff);
            wd_d      = Wr_Data;
            offset_d  = FirstOff + OffOne;
            state_d   = FILL;
          end else begin
            dropInc = OffOne;
          end
        end
      end

      FILL: begin
        if (Wr_En) begin
          wen_d = 1'b1;
          wd_d  = Wr_Data;
          if (Frame_Start) begin
            // Restart in the same bank; count the CPU bytes of the abandoned frame.
            dropInc  = offset_q - FirstOff;
            wa_d     = addrOf(bankSel_q, FirstOff);
            offset_d = FirstOff + OffOne;
          end else begin
            wa_d = addrOf(bankSel_q, offset_q);
            if (offset_q == LastOff) begin
              offset_d = '0;
              state_d  = COMMIT;
            end else begin
              offset_d = offset_q + OffOne;
            end
          end
        end
      end

      COMMIT: begin
        if (Wr_En) begin
          dropInc = OffOne;
        end
        state_d    = IDLE;
        nextBank_d = ~nextBank_q;
        if (SeqEn) begin
          // Sequence byte goes out now; the flag follows one cycle after this write.
          wen_d  = 1'b1;
          wa_d   = addrOf(bankSel_q, '0);
          wd_d   = seq_q;
          seq_d  = seq_q + 8'd1;
          setA_d = ~bankSel_q;
          setB_d = bankSel_q;
        end else if (bankSel_q) begin
          flagB_d = 1'b1;
        end else begin
          flagA_d = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase

    if (setA_q) flagA_d = 1'b1;
    if (setB_q) flagB_d = 1'b1;
    if (finEdgeA && flagA_q) flagA_d = 1'b0;
    if (finEdgeB && flagB_q) flagB_d = 1'b0;

    dropSum = {1'b0, drop_q} + {{(DROP_W+1-OFF_W){1'b0}}, dropInc};
    drop_d  = dropSum[DROP_W] ? '1 : dropSum[DROP_W-1:0];

    ready_d = (state_d == FILL) |
              ((state_d == IDLE) & (~(flagA_d | setA_d) | ~(flagB_d | setB_d)));
  end

  // State and output registers; reset discards any partial frame and frees both banks.
  always_ff @(posedge ClkI_Dec2 or posedge Rst) begin
    if (Rst) begin
      state_q    <= IDLE;
      offset_q   <= '0;
      bankSel_q  <= 1'b0;
      nextBank_q <= 1'b0;
      flagA_q    <= 1'b0;
      flagB_q    <= 1'b0;
      setA_q     <= 1'b0;
      setB_q     <= 1'b0;
      finDlyA_q  <= 1'b0;
      finDlyB_q  <= 1'b0;
      seq_q      <= '0;
      wen_q      <= 1'b0;
      wa_q       <= '0;
      wd_q       <= '0;
      ready_q    <= 1'b0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      offset_q   <= offset_d;
      bankSel_q  <= bankSel_d;
      nextBank_q <= nextBank_d;
      flagA_q    <= flagA_d;
      flagB_q    <= flagB_d;
      setA_q     <= setA_d;
      setB_q     <= setB_d;
      finDlyA_q  <= Flag_A_Tx_Finish;
      finDlyB_q  <= Flag_B_Tx_Finish;
      seq_q      <= seq_d;
      wen_q      <= wen_d;
      wa_q       <= wa_d;
      wd_q       <= wd_d;
      ready_q    <= ready_d;
      drop_q     <= drop_d;
    end
  end

  assign Wr_Ready      = ready_q;
  assign USER_WEN_TRP1 = wen_q;
  assign USER_WA_TRP1  = wa_q;
  assign USER_WD_TRP1  = wd_q;
  assign Flag_A_Tx     = flagA_q;
  assign Flag_B_Tx     = flagB_q;
  assign pending       = flagA_q | flagB_q;
  assign Drop_Count    = drop_q;

endmodule
